// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory-port arbiter.
//   - HOLD_* : pipeline hold codes driven onto HOLD_FLAG_BUS [2:0]
//   - arb_state_t : arbiter FSM states
//   - gnt_t : grant codes produced by the priority encoder
//   - ZERO_WORD : all-zero data word
package mem_arbiter_pkg;

  typedef logic [2:0] hold_flag_t;

  localparam hold_flag_t HOLD_NONE = 3'b000;
  localparam hold_flag_t HOLD_PC   = 3'b001;
  localparam hold_flag_t HOLD_IF   = 3'b010;
  localparam hold_flag_t HOLD_ID   = 3'b011;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2,
    GNT_M2   = 2'd3
  } gnt_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/arb_prio_enc.sv
// arb_prio_enc: combinational fixed-priority encoder for three requesters.
//   Priority m2 > m0 > m1.
//   req_m0, req_m1, req_m2 : request lines
//   gnt                    : GNT_* code of the winner, GNT_NONE if no request
module arb_prio_enc
  import mem_arbiter_pkg::*;
(
  input  logic req_m0,
  input  logic req_m1,
  input  logic req_m2,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req_m2) begin
      gnt = GNT_M2;
    end else if (req_m0) begin
      gnt = GNT_M0;
    end else if (req_m1) begin
      gnt = GNT_M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between debug (m2), load/store
// (m0) and instruction fetch (m1). Fixed priority, grant locked until the
// slave acks or the per-transaction timeout expires.
//   clk, rst            : core clock, asynchronous active-low reset
//   m0_*                : execute-stage load/store master
//   m1_*                : fetch master (read-only)
//   m2_*                : debug master
//   s_*                 : memory slave port (s_ack_i is a one-cycle pulse)
//   hold_flag_o         : pipeline hold code
//   err_o               : one-cycle pulse when a transaction times out
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,

  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,

  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic [DATA_W-1:0] m2_rdata_o,
  output logic              m2_ack_o,

  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_ack_i,

  output logic [2:0]        hold_flag_o,
  output logic              err_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_t  state_q, state_d;
  gnt_t        gnt_q, gnt_d;
  gnt_t        gnt_win;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy;
  logic        tmo;
  logic        done;
  logic        ack_any;
  logic [DATA_W-1:0] rdata_any;

  arb_prio_enc u_prio_enc (
    .req_m0 (m0_req_i),
    .req_m1 (m1_req_i),
    .req_m2 (m2_req_i),
    .gnt    (gnt_win)
  );

  assign busy = (state_q == ARB_BUSY);
  // A real ack in the same cycle suppresses the timeout.
  assign tmo  = busy && (cnt_q == TMO_LAST) && !s_ack_i;
  assign done = busy && (s_ack_i || tmo);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (gnt_win != GNT_NONE) begin
          state_d = ARB_BUSY;
          gnt_d   = gnt_win;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          state_d = ARB_IDLE;
          gnt_d   = GNT_NONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = GNT_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: slave routing, master responses, hold code
  always_comb begin
    s_req_o     = 1'b0;
    s_we_o      = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    m2_ack_o    = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    m2_rdata_o  = '0;
    err_o       = tmo;
    hold_flag_o = HOLD_NONE;

    ack_any   = s_ack_i || tmo;
    rdata_any = tmo ? DATA_W'(ZERO_WORD) : s_rdata_i;

    if (busy) begin
      s_req_o = 1'b1;
      unique case (gnt_q)
        GNT_M0: begin
          s_we_o     = m0_we_i;
          s_addr_o   = m0_addr_i;
          s_wdata_o  = m0_wdata_i;
          m0_ack_o   = ack_any;
          m0_rdata_o = rdata_any;
        end
        GNT_M1: begin
          s_addr_o   = m1_addr_i;
          m1_ack_o   = ack_any;
          m1_rdata_o = rdata_any;
        end
        GNT_M2: begin
          s_we_o     = m2_we_i;
          s_addr_o   = m2_addr_i;
          s_wdata_o  = m2_wdata_i;
          m2_ack_o   = ack_any;
          m2_rdata_o = rdata_any;
        end
        default: ;
      endcase
    end

    // Hold code looks at raw requests so a stalled master freezes the
    // pipeline even before it is granted; forced quiet while in reset.
    if (!rst) begin
      hold_flag_o = HOLD_NONE;
    end else if ((busy && gnt_q == GNT_M2) || m2_req_i) begin
      hold_flag_o = HOLD_ID;
    end else if (m0_req_i && !m0_ack_o) begin
      hold_flag_o = HOLD_ID;
    end else if (m1_req_i && !m1_ack_o) begin
      hold_flag_o = HOLD_PC;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single data/instruction memory port between three masters: debug (m2), execute-stage load/store (m0) and instruction fetch (m1).
- Fixed-priority, lock-until-ack arbiter with a per-transaction timeout.
- Drives the pipeline hold code to pc_reg/if_id/id_ex so that stalled masters freeze the pipeline.
- Sits between ex/pc_reg/debug module and the memory slave.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT, 15, BUSY cycles without s_ack_i before forced completion; legal range 1..255

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- m0_req_i  in  1  ex load/store request
- m0_we_i  in  1  ex write enable
- m0_addr_i  in  ADDR_W  ex address
- m0_wdata_i  in  DATA_W  ex write data
- m0_rdata_o  out  DATA_W  ex read data
- m0_ack_o  out  1  ex transaction complete
- m1_req_i  in  1  fetch request (read-only)
- m1_addr_i  in  ADDR_W  fetch address (pc)
- m1_rdata_o  out  DATA_W  fetched instruction
- m1_ack_o  out  1  fetch complete
- m2_req_i  in  1  debug request
- m2_we_i  in  1  debug write enable
- m2_addr_i  in  ADDR_W  debug address
- m2_wdata_i  in  DATA_W  debug write data
- m2_rdata_o  out  DATA_W  debug read data
- m2_ack_o  out  1  debug complete
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_rdata_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave done, one-cycle pulse
- hold_flag_o  out  3  pipeline hold code (HOLD_FLAG_BUS)
- err_o  out  1  timeout pulse

Behaviour:
- Reset (rst low, async): state IDLE, grant NONE, timeout counter 0, err_o 0.
  - All slave outputs, all acks and all rdata outputs are 0.
  - hold_flag_o is HOLD_NONE.
- Priority is m2 > m0 > m1.
- IDLE state:
  - On any clock edge with at least one request, latch the winner into the grant register and go to BUSY.
  - s_req_o stays 0 while in IDLE.
- BUSY state:
  - s_req_o = 1. s_addr_o, s_we_o and s_wdata_o pass combinationally from the granted master; s_we_o is forced to 0 when m1 is granted.
  - The granted master's rdata and ack follow s_rdata_i and s_ack_i combinationally.
  - Non-granted masters see ack 0 and rdata 0.
- Completion:
  - On s_ack_i, return to IDLE and clear the counter.
  - Exactly one idle bubble separates consecutive transactions; minimum request-to-ack latency is 2 cycles.
- Masters hold req and all request fields stable until ack.
  - If a granted master drops req, the grant is still held until ack or timeout; its ack is still generated.
- Timeout:
  - The counter increments every BUSY cycle without s_ack_i.
  - When the counter equals TIMEOUT-1 and s_ack_i is 0: drive the granted master's ack = 1 with rdata = 0, pulse err_o for 1 cycle, go to IDLE.
  - If s_ack_i and the timeout fire in the same cycle, the ack wins and err_o stays 0.
  - A late s_ack_i arriving in IDLE is ignored.
- hold_flag_o (combinational, first match wins):
  - m2 granted or m2_req_i → HOLD_ID.
  - m0_req_i and not m0_ack_o → HOLD_ID.
  - m1_req_i and not m1_ack_o → HOLD_PC.
  - Otherwise HOLD_NONE.
- Reset asserted mid-transaction aborts immediately to the reset values; the slave must tolerate s_req_o dropping.

Decomposition:
- defines.v holds:
  - HOLD_NONE 3'b000, HOLD_PC 3'b001, HOLD_IF 3'b010, HOLD_ID 3'b011 (HOLD_FLAG_BUS [2:0]).
  - ARB_IDLE and ARB_BUSY state codes.
  - GNT_NONE, GNT_M0, GNT_M1, GNT_M2 grant codes.
  - ZERO_WORD.
- Sub-module arb_prio_enc: combinational 3-request fixed-priority encoder producing a GNT_* code.
- FSM, counter and routing muxes live in mem_arbiter.

Test Plan:
- m1_req_i=1, m1_addr_i=0x100, slave acks 1 cycle after s_req_o with rdata 0x00500093 → s_addr_o=0x100, s_we_o=0, m1_ack_o pulses with m1_rdata_o=0x00500093, hold_flag_o=HOLD_PC until the ack.
- m0 (we=1, addr 0x2000, wdata 0xCAFEBABE) and m1 request in the same cycle → m0 granted first; s_wdata_o=0xCAFEBABE; hold_flag_o=HOLD_ID; m1 granted after a one-cycle bubble.
- m2 and m0 request simultaneously → m2 served first and m0 waits. A new m2 request raised while m0 is BUSY does not preempt m0.
- Slave never acks, TIMEOUT=15 → ack with rdata 0 and a 1-cycle err_o pulse on the 15th BUSY cycle. A late s_ack_i afterwards produces no ack.
- s_ack_i on the same cycle the timeout would fire → normal ack, err_o=0.
- rst asserted low while BUSY → s_req_o, acks and err_o are 0 asynchronously and hold_flag_o=HOLD_NONE; after release, a pending m1 request is granted from IDLE.
